lane_scheduler: RTL and testbench

- Owns the 16 car positions consumed by vga_display and advances them once per frame, only during vertical blanking, so the renderer never sees a half-updated frame.
- Sequences one car per clock through a fixed STEP pass, with per-lane speed dividers, a direction per lane and column wrap-around.
- Sits between the VGA timing (vblank pulse source) and vga_display (car_x/car_y inputs).

---
 rtl/lane_scheduler_pkg.sv | 8 +
 rtl/lane_scheduler_if.sv | 18 +
 rtl/lane_scheduler_divider.sv | 21 ++
 rtl/lane_scheduler.sv | 96 +++++++++
 tb/tb_lane_scheduler.sv | 138 +++++++++++++
 5 files changed

// File: rtl/lane_scheduler_pkg.sv
// lane_pkg: lane speed table, car start columns and scheduler state type.
package lane_pkg;
  localparam int NUM_LANES = 8;
  localparam logic [3:0] LANE_PERIOD [NUM_LANES] = '{4'd8, 4'd6, 4'd5, 4'd4, 4'd7, 4'd3, 4'd6, 4'd2};
  localparam logic [4:0] INIT_COL [16] = '{5'd0, 5'd10, 5'd3, 5'd13, 5'd6, 5'd16, 5'd9, 5'd19,
                                           5'd12, 5'd2, 5'd15, 5'd5, 5'd18, 5'd8, 5'd1, 5'd11};
  typedef enum logic [1:0] {IDLE, STEP, DONE} state_e;
endpackage

// File: rtl/lane_scheduler_if.sv
// lane_scheduler_if: frame/game controls in, packed car positions and pass status out.
interface lane_scheduler_if;
  logic        vblank_start;
  logic        game_run;
  logic [2:0]  level;
  logic [4:0]  frog_col;
  logic [3:0]  frog_row;
  logic [79:0] car_x;
  logic [63:0] car_y;
  logic        busy;
  logic        update_done;
  logic        overrun;
  logic        hit;
  modport master (output vblank_start, game_run, level, frog_col, frog_row,
                  input car_x, car_y, busy, update_done, overrun, hit);
  modport slave (input vblank_start, game_run, level, frog_col, frog_row,
                 output car_x, car_y, busy, update_done, overrun, hit);
endinterface

// File: rtl/lane_scheduler_divider.sv
// lane_divider: per-lane frame counter; fire when the counter reaches the level-reduced period.
module lane_divider #(
  parameter logic [3:0] PERIOD = 4'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] level,
  input  logic       cnt_en,
  input  logic       clr,
  output logic       fire
);
  logic [3:0] cnt_q, cnt_d, eff;
  always_comb begin
    eff = ({1'b0, level} >= PERIOD) ? 4'd1 : PERIOD - {1'b0, level};
    fire = cnt_q >= eff - 4'd1;
    cnt_d = clr ? 4'd0 : cnt_en ? cnt_q + 4'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/lane_scheduler.sv
// lane_scheduler: advances 16 car columns one car per clock during vblank.
// Optional COLLISION_CHECK_EN builds the frog comparators that drive hit.
module lane_scheduler
  import lane_pkg::*;
#(
  parameter int NUM_COLS  = 20,
  parameter int LANE_ROW0 = 2,
  parameter int NUM_CARS  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lane_scheduler_if.slave  bus
);
  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       fire_q, fire_d, overrun_q, overrun_d;
  logic [4:0] car_x_q [NUM_CARS];
  logic [4:0] car_x_d [NUM_CARS];
  logic [NUM_LANES-1:0] fire, cnt_en, clr, lane_sel;
  logic [2:0] lane;
  logic       step, first, mv, hit_w;
  logic [4:0] x_cur, x_nxt;
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_divider #(.PERIOD(LANE_PERIOD[g])) u_div (
      .clk(clk), .rst_n(rst_n), .level(bus.level),
      .cnt_en(cnt_en[g]), .clr(clr[g]), .fire(fire[g])
    );
  end
  for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
    assign bus.car_x[5*i +: 5] = car_x_q[i];
    assign bus.car_y[4*i +: 4] = 4'(LANE_ROW0 + i / 2);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = (state_q == IDLE && bus.vblank_start && bus.game_run) ? STEP :
              (state_q == STEP && idx_q == 4'd15) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
  end
  always_comb begin
    bus.busy = state_q == STEP;
    bus.update_done = state_q == DONE;
    bus.hit = hit_w;
    bus.overrun = overrun_q;
  end
  // Second car of a lane reuses the decision latched on the first, since the counter is already cleared.
  always_comb begin
    step = state_q == STEP;
    lane = idx_q[3:1];
    first = !idx_q[0];
    mv = step && (first ? fire[lane] : fire_q);
    x_cur = car_x_q[idx_q];
    x_nxt = lane[0] ? (x_cur == 5'd0 ? 5'(NUM_COLS - 1) : x_cur - 5'd1)
                    : (x_cur == 5'(NUM_COLS - 1) ? 5'd0 : x_cur + 5'd1);
    lane_sel = (step && first) ? NUM_LANES'(1) << lane : '0;
    clr = lane_sel & fire;
    cnt_en = lane_sel & ~fire;
    idx_d = step ? idx_q + 4'd1 : 4'd0;
    fire_d = (step && first) ? fire[lane] : fire_q;
    overrun_d = overrun_q | (bus.vblank_start && state_q != IDLE);
    car_x_d = car_x_q;
    if (mv) car_x_d[idx_q] = x_nxt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx_q <= 4'd0;
      fire_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_CARS; i++) car_x_q[i] <= INIT_COL[i];
    end else begin
      idx_q <= idx_d;
      fire_q <= fire_d;
      overrun_q <= overrun_d;
      car_x_q <= car_x_d;
    end
`ifdef COLLISION_CHECK_EN
  logic       hit_q, hit_d;
  logic [4:0] x_post;
  logic [3:0] y_cur;
  always_comb begin
    x_post = mv ? x_nxt : x_cur;
    y_cur = 4'(LANE_ROW0) + {1'b0, lane};
    hit_d = (state_q == IDLE) ? 1'b0 :
            (step && x_post == bus.frog_col && y_cur == bus.frog_row) ? 1'b1 : hit_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hit_q <= 1'b0;
    else hit_q <= hit_d;
  assign hit_w = hit_q && state_q == DONE;
`else
  logic unused_frog;
  assign unused_frog = ^{bus.frog_col, bus.frog_row};
  assign hit_w = 1'b0;
`endif
endmodule

// File: tb/tb_lane_scheduler.sv
// tb_lane_scheduler: directed and random vblank passes checked against a per-lane reference model.
module tb_lane_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lane_scheduler_if b();
  lane_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(b));
`ifdef COLLISION_CHECK_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif
  localparam int PER [8] = '{8, 6, 5, 4, 7, 3, 6, 2};
  int tests = 0, fails = 0;
  int pos [16];
  int cnt [8];
  bit ov_exp = 1'b0, hit_exp = 1'b0, hit_seen = 1'b0;
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [79:0] exp_x();
    logic [79:0] r;
    for (int i = 0; i < 16; i++) r[5*i +: 5] = 5'(pos[i]);
    return r;
  endfunction
  function automatic logic [63:0] exp_y();
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = 4'(2 + i / 2);
    return r;
  endfunction
  task automatic model_pass(input int lvl);
    hit_exp = 1'b0;
    for (int l = 0; l < 8; l++) begin
      int eff;
      eff = (PER[l] - lvl < 1) ? 1 : PER[l] - lvl;
      if (cnt[l] >= eff - 1) begin
        cnt[l] = 0;
        for (int k = 0; k < 2; k++)
          pos[2*l+k] = (l % 2 == 0) ? (pos[2*l+k] + 1) % 20 : (pos[2*l+k] + 19) % 20;
      end else cnt[l]++;
      for (int k = 0; k < 2; k++)
        if (pos[2*l+k] == int'(b.frog_col) && 2 + l == int'(b.frog_row)) hit_exp = 1'b1;
    end
  endtask
  // One vblank pulse, then cycles 1..18 checked for busy/update_done/hit timing.
  task automatic pass(input int extra_at, input int drop_at);
    bit run;
    run = b.game_run;
    hit_seen = 1'b0;
    if (run) model_pass(int'(b.level));
    @(negedge clk);
    b.vblank_start = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      b.vblank_start = (c == extra_at);
      if (c == drop_at) b.game_run = 1'b0;
      chk("busy", 80'(b.busy), 80'(run && c <= 16));
      chk("update_done", 80'(b.update_done), 80'(run && c == 17));
      chk("hit", 80'(b.hit), 80'(HIT_EN && run && c == 17 && hit_exp));
      if (b.hit) hit_seen = 1'b1;
    end
    if (run && extra_at > 0) ov_exp = 1'b1;
    chk("car_x", b.car_x, exp_x());
    chk("car_y", 80'(b.car_y), 80'(exp_y()));
    chk("overrun", 80'(b.overrun), 80'(ov_exp));
  endtask
  initial begin
    b.vblank_start = 1'b0;
    b.game_run = 1'b0;
    b.level = 3'd0;
    b.frog_col = 5'd0;
    b.frog_row = 4'd15;
    for (int i = 0; i < 16; i++) pos[i] = (3 * (i / 2) + 10 * (i % 2)) % 20;
    for (int l = 0; l < 8; l++) cnt[l] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy_in_reset", 80'(b.busy), 80'(0));
    chk("rst_car_x_in_reset", b.car_x, exp_x());
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_car0", 80'(b.car_x[4:0]), 80'(0));
    chk("rst_car1", 80'(b.car_x[9:5]), 80'(10));
    chk("rst_y0", 80'(b.car_y[3:0]), 80'(2));
    chk("rst_y15", 80'(b.car_y[63:60]), 80'(9));
    chk("rst_busy", 80'(b.busy), 80'(0));
    chk("rst_done", 80'(b.update_done), 80'(0));
    chk("rst_overrun", 80'(b.overrun), 80'(0));
    chk("rst_hit", 80'(b.hit), 80'(0));
    chk("rst_car_x", b.car_x, exp_x());
    b.game_run = 1'b1;
    pass(0, 0);
    chk("lane7_hold_c14", 80'(b.car_x[74:70]), 80'(1));
    chk("lane7_hold_c15", 80'(b.car_x[79:75]), 80'(11));
    pass(0, 0);
    chk("lane7_move_c14", 80'(b.car_x[74:70]), 80'(0));
    chk("lane7_move_c15", 80'(b.car_x[79:75]), 80'(10));
    b.game_run = 1'b0;
    repeat (10) pass(0, 0);
    b.game_run = 1'b1;
    b.level = 3'd7;
    for (int n = 0; n < 20 && pos[0] != 19; n++) pass(0, 0);
    chk("lane0_at19", 80'(b.car_x[4:0]), 80'(19));
    pass(0, 0);
    chk("lane0_wrap", 80'(b.car_x[4:0]), 80'(0));
    for (int n = 0; n < 20 && pos[2] != 0; n++) pass(0, 0);
    chk("lane1_at0", 80'(b.car_x[14:10]), 80'(0));
    pass(0, 0);
    chk("lane1_wrap", 80'(b.car_x[14:10]), 80'(19));
    for (int n = 0; n < 20 && pos[0] != 0; n++) pass(0, 0);
    b.frog_col = 5'd1;
    b.frog_row = 4'd2;
    pass(0, 0);
    chk("hit_frog_row2", 80'(hit_seen), 80'(HIT_EN));
    b.frog_row = 4'd12;
    pass(0, 0);
    chk("hit_frog_row12", 80'(hit_seen), 80'(0));
    b.frog_row = 4'd15;
    b.level = 3'd0;
    chk("overrun_before", 80'(b.overrun), 80'(0));
    pass(5, 0);
    chk("overrun_set", 80'(b.overrun), 80'(1));
    pass(0, 8);
    pass(0, 0);
    chk("overrun_sticky", 80'(b.overrun), 80'(1));
    for (int n = 0; n < 40; n++) begin
      b.level = 3'($urandom_range(0, 7));
      b.game_run = $urandom_range(0, 3) != 0;
      b.frog_col = 5'($urandom_range(0, 19));
      b.frog_row = 4'($urandom_range(0, 15));
      pass(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 17)) : 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
